// File: rtl/vis_pkg.sv
// -----------------------------------------------------------------------------
// vis_pkg
// Shared types and width constants for the vector issue scoreboard (vis_sb).
//   VIS_LANES_W   : lane datapath width (bits)
//   VIS_UOP_W     : micro-op (alu_op) width
//   VIS_VREG_NUM  : vector registers tracked; VIS_VREG_AW is the index width
//   VIS_MASK_W    : one mask bit per byte of a lane word
//   VIS_MAX_LOADS : outstanding load limit; VIS_LDCNT_W is the counter width
//   vis_ex_t      : the decoded micro-op plus its operands, as held in the
//                   execute handoff register.
// The struct is sized from these constants, so vis_sb parameters should be
// left at (or kept in step with) the package defaults.
// -----------------------------------------------------------------------------
package vis_pkg;

    localparam int VIS_LANES_W   = 64;
    localparam int VIS_UOP_W     = 9;
    localparam int VIS_VREG_NUM  = 32;
    localparam int VIS_VREG_AW   = $clog2(VIS_VREG_NUM);
    localparam int VIS_MASK_W    = VIS_LANES_W / 8;
    localparam int VIS_MAX_LOADS = 4;
    localparam int VIS_LDCNT_W   = $clog2(VIS_MAX_LOADS + 1);

    typedef struct packed {
        logic [VIS_LANES_W-1:0] operand_1;
        logic [VIS_LANES_W-1:0] operand_2;
        logic [VIS_LANES_W-1:0] operand_3;
        logic [VIS_LANES_W-1:0] immediate;
        logic [VIS_LANES_W-1:0] scalar;
        logic [VIS_MASK_W-1:0]  mask_bits;
        logic [VIS_UOP_W-1:0]   alu_op;
        logic                   masked;
        logic                   load;
        logic                   store;
        logic                   indexed;
        logic                   wb_en;
        logic                   mul;
        logic [2:0]             sew;
        logic [VIS_VREG_AW-1:0] destination;
    } vis_ex_t;

endpackage

// File: rtl/vis_scoreboard.sv
// -----------------------------------------------------------------------------
// vis_scoreboard
// Per-register pending bits plus the outstanding-load counter.
// Ports:
//   clk, rst                : clock, synchronous active-low reset
//   set_en / set_addr       : mark a register pending (issue of a writer)
//   wb_clr_en / wb_clr_addr : writeback retires a pending register
//   ld_clr_en / ld_clr_addr : load return retires a pending register and
//                             one outstanding load
//   load_issue              : a load was issued this cycle
//   pending                 : one bit per vector register
//   pending_loads           : outstanding load count
//   busy                    : any pending bit set
// -----------------------------------------------------------------------------
module vis_scoreboard
    import vis_pkg::*;
#(
    parameter int VREG_NUM  = VIS_VREG_NUM,
    parameter int MAX_LOADS = VIS_MAX_LOADS
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               set_en,
    input  logic [$clog2(VREG_NUM)-1:0]        set_addr,
    input  logic                               wb_clr_en,
    input  logic [$clog2(VREG_NUM)-1:0]        wb_clr_addr,
    input  logic                               ld_clr_en,
    input  logic [$clog2(VREG_NUM)-1:0]        ld_clr_addr,
    input  logic                               load_issue,
    output logic [VREG_NUM-1:0]                pending,
    output logic [$clog2(MAX_LOADS+1)-1:0]     pending_loads,
    output logic                               busy
);

    localparam int AW = $clog2(VREG_NUM);
    localparam int CW = $clog2(MAX_LOADS + 1);

    genvar gi;
    generate
        for (gi = 0; gi < VREG_NUM; gi++) begin : g_pend
            logic set_hit;
            logic clr_hit;
            logic pend_reg;
            logic pend_next;

            assign set_hit = set_en && (set_addr == AW'(gi));
            assign clr_hit = (wb_clr_en && (wb_clr_addr == AW'(gi))) ||
                             (ld_clr_en && (ld_clr_addr == AW'(gi)));

            // A new writer issued in the same cycle as the old one retires
            // must keep the register pending.
            always_comb begin
                pend_next = pend_reg;
                if (set_hit) begin
                    pend_next = 1'b1;
                end else if (clr_hit) begin
                    pend_next = 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                if (!rst) begin
                    pend_reg <= 1'b0;
                end else begin
                    pend_reg <= pend_next;
                end
            end

            assign pending[gi] = pend_reg;
        end
    endgenerate

    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;

    // Issue and return in one cycle cancel out; a stray return with nothing
    // outstanding must not wrap the counter.
    always_comb begin
        cnt_next = cnt_reg;
        if (load_issue && !ld_clr_en) begin
            cnt_next = cnt_reg + CW'(1);
        end else if (!load_issue && ld_clr_en && (cnt_reg != '0)) begin
            cnt_next = cnt_reg - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign pending_loads = cnt_reg;
    assign busy          = |pending;

endmodule

// File: rtl/vis_sb.sv
// -----------------------------------------------------------------------------
// vis_sb
// Vector issue stage: checks the micro-op's registers against the scoreboard,
// reads the register file and hands the decoded op to execute through a
// one-deep valid/ready register.
// Build option: define VIS_SB_FORWARD_EN to let a same-cycle writeback or load
// return satisfy a pending source (data bypassed, load data first). Without it
// such an operand waits one cycle and is read from the register file.
// Ports:
//   clk, rst                          : clock, synchronous active-low reset
//   in_valid / in_ready               : micro-op handshake
//   alu_op, operand_1/2, destination,
//   mask_bits, flags, sew_in,
//   operand_1_immediate/_scalar       : decoded micro-op
//   rf_addr_1/2/3 -> rf_data_1/2/3    : combinational register-file read
//   ex_valid / ex_ready / ex_data     : execute handoff
//   wrdata, indexed                   : store data / index operand of ex op
//   wait_load_signal, load_destination: load handoff pulse and its target
//   write_back_enable_wb, destination_write, data_write : writeback
//   read_done, load_data_destination, data_from_load    : load return
//   busy, pending_loads               : scoreboard status
// -----------------------------------------------------------------------------
module vis_sb
    import vis_pkg::*;
#(
    parameter int LANES_DATA_WIDTH = VIS_LANES_W,
    parameter int MICROOP_BIT      = VIS_UOP_W,
    parameter int VREG_NUM         = VIS_VREG_NUM,
    parameter int MAX_LOADS        = VIS_MAX_LOADS
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [MICROOP_BIT-1:0]          alu_op,
    input  logic [$clog2(VREG_NUM)-1:0]     operand_1,
    input  logic [$clog2(VREG_NUM)-1:0]     operand_2,
    input  logic [$clog2(VREG_NUM)-1:0]     destination,
    input  logic [LANES_DATA_WIDTH/8-1:0]   mask_bits,
    input  logic                            masked_operation,
    input  logic                            load_operation,
    input  logic                            store_operation,
    input  logic                            indexed_memory_operation,
    input  logic                            write_back_enable,
    input  logic                            multiplication_flag,
    input  logic [2:0]                      sew_in,
    input  logic [LANES_DATA_WIDTH-1:0]     operand_1_immediate,
    input  logic [LANES_DATA_WIDTH-1:0]     operand_1_scalar,
    output logic [$clog2(VREG_NUM)-1:0]     rf_addr_1,
    output logic [$clog2(VREG_NUM)-1:0]     rf_addr_2,
    output logic [$clog2(VREG_NUM)-1:0]     rf_addr_3,
    input  logic [LANES_DATA_WIDTH-1:0]     rf_data_1,
    input  logic [LANES_DATA_WIDTH-1:0]     rf_data_2,
    input  logic [LANES_DATA_WIDTH-1:0]     rf_data_3,
    output logic                            ex_valid,
    input  logic                            ex_ready,
    output vis_ex_t                         ex_data,
    output logic [LANES_DATA_WIDTH-1:0]     wrdata,
    output logic [LANES_DATA_WIDTH-1:0]     indexed,
    output logic                            wait_load_signal,
    output logic [$clog2(VREG_NUM)-1:0]     load_destination,
    input  logic                            write_back_enable_wb,
    input  logic [$clog2(VREG_NUM)-1:0]     destination_write,
    input  logic [LANES_DATA_WIDTH-1:0]     data_write,
    input  logic                            read_done,
    input  logic [$clog2(VREG_NUM)-1:0]     load_data_destination,
    input  logic [LANES_DATA_WIDTH-1:0]     data_from_load,
    output logic                            busy,
    output logic [$clog2(MAX_LOADS+1)-1:0]  pending_loads
);

    localparam int AW  = $clog2(VREG_NUM);
    localparam int LCW = $clog2(MAX_LOADS + 1);

    logic [VREG_NUM-1:0]         pending;
    logic [AW-1:0]               src_addr [3];
    logic [LANES_DATA_WIDTH-1:0] src_rf   [3];
    logic [LANES_DATA_WIDTH-1:0] src_data [3];
    logic [2:0]                  src_blocked;
    logic                        hazard;
    logic                        load_full;
    logic                        issue;

    assign rf_addr_1 = operand_1;
    assign rf_addr_2 = operand_2;
    assign rf_addr_3 = destination;

    // Slot 2 is the destination: it is both a WAW check and the store-data read.
    assign src_addr[0] = operand_1;
    assign src_addr[1] = operand_2;
    assign src_addr[2] = destination;
    assign src_rf[0]   = rf_data_1;
    assign src_rf[1]   = rf_data_2;
    assign src_rf[2]   = rf_data_3;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_src
`ifdef VIS_SB_FORWARD_EN
            logic ld_hit;
            logic wb_hit;
            assign ld_hit = read_done && (load_data_destination == src_addr[gi]);
            assign wb_hit = write_back_enable_wb && (destination_write == src_addr[gi]);
            assign src_blocked[gi] = pending[src_addr[gi]] && !(ld_hit || wb_hit);
            assign src_data[gi]    = ld_hit ? data_from_load :
                                     (wb_hit ? data_write : src_rf[gi]);
`else
            assign src_blocked[gi] = pending[src_addr[gi]];
            assign src_data[gi]    = src_rf[gi];
`endif
        end
    endgenerate

`ifndef VIS_SB_FORWARD_EN
    // Bypass data is only consumed by the forwarding build.
    logic fwd_unused;
    assign fwd_unused = ^{data_write, data_from_load};
`endif

    assign hazard    = |src_blocked;
    assign load_full = load_operation && (pending_loads == LCW'(MAX_LOADS));
    assign in_ready  = !hazard && !load_full && (!ex_valid || ex_ready);
    assign issue     = in_valid && in_ready;

    vis_scoreboard #(
        .VREG_NUM  (VREG_NUM),
        .MAX_LOADS (MAX_LOADS)
    ) u_scoreboard (
        .clk           (clk),
        .rst           (rst),
        .set_en        (issue && (write_back_enable || load_operation)),
        .set_addr      (destination),
        .wb_clr_en     (write_back_enable_wb),
        .wb_clr_addr   (destination_write),
        .ld_clr_en     (read_done),
        .ld_clr_addr   (load_data_destination),
        .load_issue    (issue && load_operation),
        .pending       (pending),
        .pending_loads (pending_loads),
        .busy          (busy)
    );

    vis_ex_t ex_reg;
    vis_ex_t ex_next;
    logic    ex_valid_reg;
    logic    ex_valid_next;

    // in_ready already folds in ex_ready, so an issue never overwrites an op
    // that execute has not taken. Data is left in place after a plain handoff.
    always_comb begin
        ex_next       = ex_reg;
        ex_valid_next = ex_valid_reg;
        if (issue) begin
            ex_valid_next         = 1'b1;
            ex_next.operand_1     = src_data[0];
            ex_next.operand_2     = src_data[1];
            ex_next.operand_3     = src_data[2];
            ex_next.immediate     = operand_1_immediate;
            ex_next.scalar        = operand_1_scalar;
            ex_next.mask_bits     = mask_bits;
            ex_next.alu_op        = alu_op;
            ex_next.masked        = masked_operation;
            ex_next.load          = load_operation;
            ex_next.store         = store_operation;
            ex_next.indexed       = indexed_memory_operation;
            ex_next.wb_en         = write_back_enable;
            ex_next.mul           = multiplication_flag;
            ex_next.sew           = sew_in;
            ex_next.destination   = destination;
        end else if (ex_ready) begin
            ex_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_reg       <= '0;
            ex_valid_reg <= 1'b0;
        end else begin
            ex_reg       <= ex_next;
            ex_valid_reg <= ex_valid_next;
        end
    end

    assign ex_valid         = ex_valid_reg;
    assign ex_data          = ex_reg;
    assign wrdata           = (ex_valid_reg && ex_reg.store) ? ex_reg.operand_3 : '0;
    assign indexed          = (ex_valid_reg && ex_reg.indexed && (ex_reg.load || ex_reg.store))
                              ? ex_reg.operand_2 : '0;
    assign wait_load_signal = ex_valid_reg && ex_ready && ex_reg.load;
    assign load_destination = ex_reg.destination;

endmodule

// File: tb/tb_vis_sb.sv
module tb_vis_sb;
    import vis_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [8:0]  alu_op;
    logic [4:0]  operand_1, operand_2, destination;
    logic [7:0]  mask_bits;
    logic        masked_operation, load_operation, store_operation;
    logic        indexed_memory_operation, write_back_enable, multiplication_flag;
    logic [2:0]  sew_in;
    logic [63:0] operand_1_immediate, operand_1_scalar;
    logic [4:0]  rf_addr_1, rf_addr_2, rf_addr_3;
    logic [63:0] rf_data_1, rf_data_2, rf_data_3;
    logic        ex_valid, ex_ready;
    vis_ex_t     ex_data;
    logic [63:0] wrdata, indexed;
    logic        wait_load_signal;
    logic [4:0]  load_destination;
    logic        write_back_enable_wb;
    logic [4:0]  destination_write;
    logic [63:0] data_write;
    logic        read_done;
    logic [4:0]  load_data_destination;
    logic [63:0] data_from_load;
    logic        busy;
    logic [2:0]  pending_loads;

    always #5 clk = ~clk;

    // Register file owned by the bench.
    logic [63:0] rf [32];
    assign rf_data_1 = rf[rf_addr_1];
    assign rf_data_2 = rf[rf_addr_2];
    assign rf_data_3 = rf[rf_addr_3];

    vis_sb dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .operand_1(operand_1), .operand_2(operand_2),
        .destination(destination), .mask_bits(mask_bits),
        .masked_operation(masked_operation), .load_operation(load_operation),
        .store_operation(store_operation),
        .indexed_memory_operation(indexed_memory_operation),
        .write_back_enable(write_back_enable), .multiplication_flag(multiplication_flag),
        .sew_in(sew_in), .operand_1_immediate(operand_1_immediate),
        .operand_1_scalar(operand_1_scalar),
        .rf_addr_1(rf_addr_1), .rf_addr_2(rf_addr_2), .rf_addr_3(rf_addr_3),
        .rf_data_1(rf_data_1), .rf_data_2(rf_data_2), .rf_data_3(rf_data_3),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_data(ex_data),
        .wrdata(wrdata), .indexed(indexed), .wait_load_signal(wait_load_signal),
        .load_destination(load_destination),
        .write_back_enable_wb(write_back_enable_wb), .destination_write(destination_write),
        .data_write(data_write), .read_done(read_done),
        .load_data_destination(load_data_destination), .data_from_load(data_from_load),
        .busy(busy), .pending_loads(pending_loads)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: set of pending registers, queue of outstanding loads,
    // and the op expected in the execute slot.
    bit      pend_set [int];
    int      ldq [$];
    bit      m_ex_valid = 1'b0;
    vis_ex_t m_ex       = '0;

    // DUT observations from the most recent cycle() call.
    bit dut_ready_q;
    bit dut_iss_q;
    int handoffs = 0;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit blocked(input int r);
        bit b;
        b = pend_set.exists(r);
`ifdef VIS_SB_FORWARD_EN
        if ((write_back_enable_wb && int'(destination_write) == r) ||
            (read_done && int'(load_data_destination) == r))
            b = 1'b0;
`endif
        return b;
    endfunction

    function automatic logic [63:0] src_val(input int r);
        logic [63:0] v;
        v = rf[r];
`ifdef VIS_SB_FORWARD_EN
        if (write_back_enable_wb && int'(destination_write) == r) v = data_write;
        if (read_done && int'(load_data_destination) == r) v = data_from_load;
`endif
        return v;
    endfunction

    function automatic bit exp_ready();
        bit haz;
        haz = blocked(int'(operand_1)) || blocked(int'(operand_2)) || blocked(int'(destination));
        return !haz && !(load_operation && ldq.size() == 4) && (!m_ex_valid || ex_ready);
    endfunction

    // One clock: check all outputs at the falling edge, then advance the model.
    task automatic cycle();
        bit          rdy, iss;
        vis_ex_t     nx;
        logic [63:0] e_wr, e_idx;
        @(negedge clk);
        rdy = exp_ready();
        dut_ready_q = in_ready;
        dut_iss_q   = in_valid && in_ready;
        if (ex_valid && ex_ready) handoffs++;
        chk("in_ready", in_ready, rdy);
        chk("rf_addr", {rf_addr_1, rf_addr_2, rf_addr_3}, {operand_1, operand_2, destination});
        chk("ex_valid", ex_valid, m_ex_valid);
        if (m_ex_valid) chk("ex_data", ex_data, m_ex);
        e_wr  = (m_ex_valid && m_ex.store) ? m_ex.operand_3 : 64'd0;
        e_idx = (m_ex_valid && m_ex.indexed && (m_ex.load || m_ex.store)) ? m_ex.operand_2 : 64'd0;
        chk("wrdata", wrdata, e_wr);
        chk("indexed", indexed, e_idx);
        chk("wait_load", wait_load_signal, m_ex_valid && ex_ready && m_ex.load);
        chk("load_dest", load_destination, m_ex.destination);
        chk("pending_loads", pending_loads, ldq.size());
        chk("busy", busy, pend_set.num() != 0);
        iss = in_valid && rdy;
        nx = '0;
        if (iss) begin
            nx.operand_1   = src_val(int'(operand_1));
            nx.operand_2   = src_val(int'(operand_2));
            nx.operand_3   = src_val(int'(destination));
            nx.immediate   = operand_1_immediate;
            nx.scalar      = operand_1_scalar;
            nx.mask_bits   = mask_bits;
            nx.alu_op      = alu_op;
            nx.masked      = masked_operation;
            nx.load        = load_operation;
            nx.store       = store_operation;
            nx.indexed     = indexed_memory_operation;
            nx.wb_en       = write_back_enable;
            nx.mul         = multiplication_flag;
            nx.sew         = sew_in;
            nx.destination = destination;
        end
        @(posedge clk);
        #1;
        if (!rst) begin
            pend_set.delete();
            ldq.delete();
            m_ex_valid = 1'b0;
            m_ex       = '0;
        end else begin
            if (iss) begin
                m_ex_valid = 1'b1;
                m_ex       = nx;
            end else if (ex_ready) begin
                m_ex_valid = 1'b0;
            end
            if (write_back_enable_wb) pend_set.delete(int'(destination_write));
            if (read_done) pend_set.delete(int'(load_data_destination));
            if (iss && (write_back_enable || load_operation)) pend_set[int'(destination)] = 1'b1;
            if (iss && load_operation) ldq.push_back(int'(destination));
            if (read_done && ldq.size() > 0) void'(ldq.pop_front());
        end
        if (write_back_enable_wb) rf[destination_write] = data_write;
        if (read_done) rf[load_data_destination] = data_from_load;
    endtask

    task automatic idle();
        rst = 1'b1; in_valid = 1'b0; alu_op = '0; operand_1 = '0; operand_2 = '0;
        destination = '0; mask_bits = '0; masked_operation = 1'b0; load_operation = 1'b0;
        store_operation = 1'b0; indexed_memory_operation = 1'b0; write_back_enable = 1'b0;
        multiplication_flag = 1'b0; sew_in = '0; operand_1_immediate = '0;
        operand_1_scalar = '0; ex_ready = 1'b1; write_back_enable_wb = 1'b0;
        destination_write = '0; data_write = '0; read_done = 1'b0;
        load_data_destination = '0; data_from_load = '0;
    endtask

    task automatic op(input int o1, input int o2, input int d,
                      input bit ld, input bit st, input bit idx, input bit wbe);
        in_valid = 1'b1;
        operand_1 = 5'(o1); operand_2 = 5'(o2); destination = 5'(d);
        load_operation = ld; store_operation = st;
        indexed_memory_operation = idx; write_back_enable = wbe;
        alu_op = 9'($urandom); mask_bits = 8'($urandom); sew_in = 3'($urandom);
        masked_operation = 1'($urandom); multiplication_flag = 1'($urandom);
        operand_1_immediate = {$urandom, $urandom};
        operand_1_scalar    = {$urandom, $urandom};
    endtask

    task automatic issue_wait(input string tag, input int max);
        bit got = 1'b0;
        for (int i = 0; i < max; i++) begin
            cycle();
            if (dut_iss_q) begin
                got = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        chk(tag, got, 1'b1);
    endtask

    task automatic rst_seq();
        idle();
        rst = 1'b0;
        cycle();
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vis_ex_t snap;
        for (int i = 0; i < 32; i++) rf[i] = {$urandom, $urandom};
        idle();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // Reset state
        chk("rst_ex_valid", ex_valid, 1'b0);
        chk("rst_ex_data", ex_data, '0);
        chk("rst_pending_loads", pending_loads, 3'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);

        // vadd v3 <- v1, v2 then a reader of v3 waits for its writeback
        op(1, 2, 3, 0, 0, 0, 1);
        issue_wait("s33_issue", 2);
        chk("s33_ex_valid", ex_valid, 1'b1);
        chk("s33_busy", busy, 1'b1);
        op(3, 0, 4, 0, 0, 0, 1);
        cycle();
        chk("s33_stall1", dut_ready_q, 1'b0);
        cycle();
        chk("s33_stall2", dut_ready_q, 1'b0);
        write_back_enable_wb = 1'b1; destination_write = 5'd3; data_write = {$urandom, $urandom};
        cycle();
        write_back_enable_wb = 1'b0;
`ifdef VIS_SB_FORWARD_EN
        chk("s33_fwd_issue", dut_ready_q, 1'b1);
`else
        chk("s33_wb_stall", dut_ready_q, 1'b0);
`endif
        if (dut_iss_q) in_valid = 1'b0;
        else issue_wait("s33_after_wb", 3);
        cycle();

        // Writeback of v5 with 0xDEAD in the same cycle as a reader of v5
        rst_seq();
        op(0, 0, 5, 0, 0, 0, 1);
        issue_wait("s36_writer", 2);
        op(5, 0, 6, 0, 0, 0, 1);
        write_back_enable_wb = 1'b1; destination_write = 5'd5; data_write = 64'hDEAD;
        cycle();
        write_back_enable_wb = 1'b0;
`ifdef VIS_SB_FORWARD_EN
        chk("s36_no_stall", dut_ready_q, 1'b1);
        in_valid = 1'b0;
`else
        chk("s36_stall", dut_ready_q, 1'b0);
        issue_wait("s36_late_issue", 2);
`endif
        chk("s36_operand", ex_data.operand_1, 64'hDEAD);
        cycle();

        // Four loads fill the counter; a fifth waits for a return
        rst_seq();
        for (int k = 0; k < 4; k++) begin
            op(0, 0, 10 + k, 1, 0, 0, 0);
            issue_wait("s34_load", 2);
        end
        op(0, 0, 14, 1, 0, 0, 0);
        cycle();
        chk("s34_full_block", dut_ready_q, 1'b0);
        chk("s34_cnt_full", pending_loads, 3'd4);
        read_done = 1'b1; load_data_destination = 5'd10; data_from_load = {$urandom, $urandom};
        cycle();
        read_done = 1'b0;
        chk("s34_rd_cycle", dut_ready_q, 1'b0);
        cycle();
        chk("s34_issue_next", dut_iss_q, 1'b1);
        in_valid = 1'b0;
        chk("s34_cnt_after", pending_loads, 3'd4);

        // Execute backpressure for 3 cycles
        rst_seq();
        op(1, 2, 3, 0, 1, 0, 0);
        issue_wait("s35_issue", 2);
        ex_ready = 1'b0;
        op(4, 5, 6, 0, 0, 0, 1);
        snap = ex_data;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("s35_in_ready", dut_ready_q, 1'b0);
            chk("s35_stable", ex_data, snap);
        end
        in_valid = 1'b0;
        ex_ready = 1'b1;
        handoffs = 0;
        cycle();
        cycle();
        chk("s35_handoffs", handoffs, 1);

        // Indexed store of v7 via v2
        rst_seq();
        op(0, 2, 7, 0, 1, 1, 0);
        issue_wait("s37_issue", 2);
        chk("s37_wrdata", wrdata, rf[7]);
        chk("s37_indexed", indexed, rf[2]);
        cycle();
        chk("s37_wrdata_idle", wrdata, 64'd0);
        chk("s37_indexed_idle", indexed, 64'd0);

        // Reset with two loads in flight
        rst_seq();
        op(0, 0, 20, 1, 0, 0, 0);
        issue_wait("s38_load_a", 2);
        op(0, 0, 21, 1, 0, 0, 0);
        issue_wait("s38_load_b", 2);
        chk("s38_cnt_before", pending_loads, 3'd2);
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        chk("s38_cnt", pending_loads, 3'd0);
        chk("s38_busy", busy, 1'b0);
        chk("s38_ex_valid", ex_valid, 1'b0);
        chk("s38_in_ready", in_ready, 1'b1);
        read_done = 1'b1; load_data_destination = 5'd20; data_from_load = {$urandom, $urandom};
        cycle();
        read_done = 1'b0;
        chk("s38_stray_return", pending_loads, 3'd0);

        // Randomized traffic on a small register window to provoke hazards
        for (int n = 0; n < 400; n++) begin
            bit ld;
            ld = ($urandom_range(99) < 30);
            op($urandom_range(7), $urandom_range(7), $urandom_range(7), ld,
               !ld && ($urandom_range(99) < 25), $urandom_range(99) < 30,
               $urandom_range(99) < 50);
            in_valid              = 1'($urandom);
            ex_ready              = ($urandom_range(99) < 70);
            rst                   = ($urandom_range(99) != 0);
            write_back_enable_wb  = ($urandom_range(99) < 25);
            destination_write     = 5'($urandom_range(7));
            data_write            = {$urandom, $urandom};
            read_done             = ($urandom_range(99) < 25);
            load_data_destination = 5'($urandom_range(7));
            data_from_load        = {$urandom, $urandom};
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vis_sb.md
VIS_SB -- requirements
Module: vis_sb

Interface
REQ-001 SHALL have parameter LANES_DATA_WIDTH, default 64, lane datapath width in bits.
REQ-002 SHALL have parameter MICROOP_BIT, default 9, width of alu_op.
REQ-003 SHALL have parameter VREG_NUM, default 32, number of vector registers tracked; VREG_AW = clog2(VREG_NUM).
REQ-004 SHALL have parameter MAX_LOADS, default 4, maximum outstanding loads.
REQ-005 SHALL have port clk  in  1  the single clock, all logic on rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous and active-low.
REQ-007 SHALL have ports in_valid  in  1 and in_ready  out  1, the micro-op handshake.
REQ-008 SHALL have ports alu_op  in  MICROOP_BIT, operand_1/operand_2/destination  in  VREG_AW, and mask_bits  in  LANES_DATA_WIDTH/8.
REQ-009 SHALL have 1-bit inputs masked_operation, load_operation, store_operation, indexed_memory_operation, write_back_enable and multiplication_flag, plus sew_in  in  3.
REQ-010 SHALL have ports operand_1_immediate and operand_1_scalar, both  in  LANES_DATA_WIDTH.
REQ-011 SHALL have ports rf_addr_1/2/3  out  VREG_AW and rf_data_1/2/3  in  LANES_DATA_WIDTH, a combinational register-file read.
REQ-012 SHALL have ports ex_valid  out  1, ex_ready  in  1, and ex_data  out  vis_ex_t, the execute handoff.
REQ-013 SHALL have ports wrdata and indexed  out  LANES_DATA_WIDTH, wait_load_signal  out  1, and load_destination  out  VREG_AW.
REQ-014 SHALL have writeback ports write_back_enable_wb  in  1, destination_write  in  VREG_AW, data_write  in  LANES_DATA_WIDTH.
REQ-015 SHALL have load-return ports read_done  in  1, load_data_destination  in  VREG_AW, data_from_load  in  LANES_DATA_WIDTH.
REQ-016 SHALL have status ports busy  out  1 (any pending bit set) and pending_loads  out  clog2(MAX_LOADS+1).

Function
REQ-017 rf_addr_1/2/3 SHALL equal operand_1/operand_2/destination combinationally.
REQ-018 Scoreboard: one pending bit per vreg, set on issue when write_back_enable or load_operation, for destination.
REQ-019 A pending bit SHALL clear on write_back_enable_wb (destination_write) or read_done (load_data_destination); if set and clear hit the same register in one cycle, set wins.
REQ-020 Hazard SHALL be true if the pending bit of operand_1, operand_2 or destination is set.
REQ-021 in_ready SHALL be !hazard && !(load_operation && pending_loads==MAX_LOADS) && (!ex_valid || ex_ready).
REQ-022 Issue (in_valid && in_ready) SHALL load the ex register with all decoded fields and rf_data_1/2/3; ex_valid rises the next cycle (latency 1).
REQ-023 While ex_valid && !ex_ready, the ex register SHALL hold; ex_valid clears on handoff without a new issue.
REQ-024 pending_loads SHALL increment on load issue and decrement on read_done; when both occur it is unchanged; read_done at 0 leaves it at 0.
REQ-025 wrdata SHALL be the ex operand_3 when ex_valid && store, else 0; indexed SHALL be the ex operand_2 when ex_valid && indexed && (load||store), else 0.
REQ-026 wait_load_signal SHALL pulse one cycle on handoff (ex_valid && ex_ready) of a load; load_destination SHALL be the ex destination.

Reset
REQ-027 When rst==0 at a clock edge: pending bits, pending_loads and ex_valid SHALL be 0, ex_data all zero, and in_ready SHALL be 1 in the following cycle.
REQ-028 A reset mid-operation SHALL discard in-flight state; a later read_done or writeback with no pending entry SHALL be harmless.

Configuration
REQ-029 With VIS_SB_FORWARD_EN defined, a same-cycle writeback or load return to a pending source SHALL count as cleared, and its data SHALL replace the matching rf_data at issue; load-return data takes priority over writeback data.
REQ-030 Without VIS_SB_FORWARD_EN, such an operand SHALL stall one cycle and issue from the register file afterwards.

Structure
REQ-031 Package vis_pkg SHALL hold vis_ex_t (operands 1–3, immediate, scalar, mask_bits, alu_op, flags, sew, destination) and the width constants.
REQ-032 The scoreboard and load counter SHALL be one sub-module, vis_scoreboard.

Verification
REQ-033 Issue vadd v3<-v1,v2 with write_back_enable -> ex_valid next cycle; v3 pending; an issue reading v3 stalls until destination_write=3 writeback.
REQ-034 Issue 4 loads (MAX_LOADS=4) -> in_ready=0 for a 5th load; one read_done -> issues next cycle; pending_loads stays 4.
REQ-035 Hold ex_ready=0 for 3 cycles -> ex_data stable, in_ready=0; release -> exactly one handoff.
REQ-036 Writeback of v5 with data 0xDEAD same cycle as an issue reading v5 -> with macro ex operand=0xDEAD, no stall; without -> one stall cycle.
REQ-037 Store indexed v7 via v2 -> wrdata=rf v7, indexed=rf v2 while ex_valid; both 0 otherwise.
REQ-038 Assert rst=0 with 2 loads pending -> pending_loads=0, busy=0, ex_valid=0 the next cycle.
